// File: rtl/i2c_bus_arbiter_if.sv
// Requester / master-core signal bundle for the two-port I2C bus arbiter.
// The arbiter connects through the slave modport; the surrounding logic
// (requesters plus the I2C master core) connects through the master modport.
interface i2c_bus_arbiter_if;
    // requester side
    logic       req0;
    logic       req1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       nack;
    logic       timeout;
    // master core side
    logic       m_start;
    logic [7:0] m_addr;
    logic [7:0] m_data;
    logic       m_done;
    logic       m_nack;
    logic [7:0] m_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1,
        input  m_done, m_nack, m_rdata,
        output gnt0, gnt1, done0, done1, rdata, nack, timeout,
        output m_start, m_addr, m_data
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1,
        output m_done, m_nack, m_rdata,
        input  gnt0, gnt1, done0, done1, rdata, nack, timeout,
        input  m_start, m_addr, m_data
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master core.
// One complete master transaction per grant: ISSUE (start pulse), WAIT
// (watchdog running), RESP (done pulse), GAP (enforced bus-free time).
// Every output is a register in the clk domain.
module i2c_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,  // >= 2
    parameter int GAP_CYCLES     = 2      // >= 1
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_bus_arbiter_if.slave   bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // The watchdog counter starts at 0 in the first WAIT cycle, so the last
    // WAIT cycle before a forced abort holds TIMEOUT_CYCLES-2; the abort
    // then lands in RESP exactly TIMEOUT_CYCLES cycles after M_START.
    localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] wd_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_srv;   // 0/1 = requester most recently served

    logic          gnt0_q, gnt1_q, done0_q, done1_q;
    logic          nack_q, timeout_q, m_start_q;
    logic [7:0]    rdata_q, m_addr_q, m_data_q;

    // Winner of the IDLE decision: the sole requester, or on a tie the one
    // that was not served last.
    logic pick1;
    assign pick1 = bus.req1 & (~bus.req0 | ~last_srv);

    // Transaction sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            gap_cnt   <= '0;
            last_srv  <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            m_start_q <= 1'b0;
            rdata_q   <= '0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        m_addr_q  <= pick1 ? bus.addr1  : bus.addr0;
                        m_data_q  <= pick1 ? bus.wdata1 : bus.wdata0;
                        gnt0_q    <= ~pick1;
                        gnt1_q    <= pick1;
                        m_start_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start_q <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion on the final count cycle beats the watchdog.
                    if (bus.m_done) begin
                        rdata_q   <= bus.m_rdata;
                        nack_q    <= bus.m_nack;
                        timeout_q <= 1'b0;
                        done0_q   <= gnt0_q;
                        done1_q   <= gnt1_q;
                        state     <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        rdata_q   <= '0;
                        nack_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        done0_q   <= gnt0_q;
                        done1_q   <= gnt1_q;
                        state     <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                RESP: begin
                    last_srv  <= gnt1_q;
                    done0_q   <= 1'b0;
                    done1_q   <= 1'b0;
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    nack_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    gap_cnt   <= '0;
                    state     <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.rdata   = rdata_q;
    assign bus.nack    = nack_q;
    assign bus.timeout = timeout_q;
    assign bus.m_start = m_start_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_data  = m_data_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed vector table, reset-abort sequence,
// then random transactions predicted by a transaction-level model.
module tb_i2c_bus_arbiter;
    localparam int T = 16;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    i2c_bus_arbiter_if bus();

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done = -1;  // cycle of previous DONE, -1 = none since reset
    int last_srv = 1;    // model: requester served last

    typedef struct {
        bit         r0, r1, idle_pre;
        logic [7:0] a0, w0, a1, w1;
        int         d;       // M_DONE cycle after M_START (-1 = never)
        bit         mn;
        logic [7:0] mr;
        int         e_gnt;
        logic [7:0] e_addr, e_data;
        int         e_lat;   // DONE cycle after M_START
        logic [7:0] e_rdata;
        bit         e_nack, e_to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // GNT must never be two-hot.
    always @(negedge clk) begin
        checks++;
        if (bus.gnt0 && bus.gnt1) begin
            errors++;
            $display("FAIL gnt_onehot: got gnt0=1 gnt1=1 expected at most one");
        end
    end

    function automatic vec_t mk(input bit r0, input bit r1, input bit ip,
                                input logic [7:0] a0, input logic [7:0] w0,
                                input logic [7:0] a1, input logic [7:0] w1,
                                input int d, input bit mn, input logic [7:0] mr,
                                input int eg, input int el, input logic [7:0] er,
                                input bit en, input bit eto);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.idle_pre = ip;
        v.a0 = a0; v.w0 = w0; v.a1 = a1; v.w1 = w1;
        v.d = d; v.mn = mn; v.mr = mr;
        v.e_gnt = eg;
        v.e_addr = eg ? a1 : a0;
        v.e_data = eg ? w1 : w0;
        v.e_lat = el; v.e_rdata = er; v.e_nack = en; v.e_to = eto;
        return v;
    endfunction

    // Transaction-level reference: who wins, and what the requester sees.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        bit ok;
        if (v.r0 && !v.r1)      o.e_gnt = 0;
        else if (v.r1 && !v.r0) o.e_gnt = 1;
        else                    o.e_gnt = (last_srv == 1) ? 0 : 1;
        o.e_addr = o.e_gnt ? v.a1 : v.a0;
        o.e_data = o.e_gnt ? v.w1 : v.w0;
        ok = (v.d >= 1) && (v.d <= T - 1);
        o.e_lat   = ok ? v.d + 1 : T;
        o.e_rdata = ok ? v.mr : 8'h00;
        o.e_nack  = ok ? v.mn : 1'b1;
        o.e_to    = !ok;
        return o;
    endfunction

    task automatic apply(input vec_t v);
        int s, got;
        logic [1:0] eg;
        eg = (v.e_gnt == 1) ? 2'b10 : 2'b01;
        if (v.idle_pre) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            bus.m_done = 1'b1;   // stray completion outside WAIT
            tick();
            bus.m_done = 1'b0;
            repeat (G + 2) tick();
        end
        bus.addr0 = v.a0; bus.wdata0 = v.w0;
        bus.addr1 = v.a1; bus.wdata1 = v.w1;
        bus.req0 = v.r0;  bus.req1 = v.r1;
        s = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.m_start) begin s = i; break; end
        end
        chk("start_seen", 32'(s > 0), 32'd1);
        if (s < 0) return;
        if (v.idle_pre) chk("start_latency", s, 1);
        if (last_done >= 0) begin
            checks++;
            if (cyc - last_done - 1 < G) begin
                errors++;
                $display("FAIL bus_gap: got %0d idle cycles expected >= %0d", cyc - last_done - 1, G);
            end
        end
        chk("gnt_issue", {bus.gnt1, bus.gnt0}, eg);
        chk("m_addr", bus.m_addr, v.e_addr);
        chk("m_data", bus.m_data, v.e_data);
        // post-latch input changes must not reach the master
        bus.addr0 = ~v.a0; bus.wdata0 = ~v.w0;
        bus.addr1 = ~v.a1; bus.wdata1 = ~v.w1;
        got = -1;
        for (int c = 1; c <= T + 8; c++) begin
            tick();
            bus.m_done  = (c == v.d);
            bus.m_nack  = (c == v.d) ? v.mn : 1'($urandom);
            bus.m_rdata = (c == v.d) ? v.mr : 8'($urandom);
            if (c == 1) chk("m_start_pulse", bus.m_start, 1'b0);
            if (bus.done0 || bus.done1) begin got = c; break; end
            chk("gnt_wait", {bus.gnt1, bus.gnt0}, eg);
        end
        bus.m_done = 1'b0;
        chk("done_latency", got, v.e_lat);
        if (got > 0) begin
            chk("done_sel", {bus.done1, bus.done0}, eg);
            chk("gnt_resp", {bus.gnt1, bus.gnt0}, eg);
            chk("rdata", bus.rdata, v.e_rdata);
            chk("nack", bus.nack, v.e_nack);
            chk("timeout", bus.timeout, v.e_to);
            chk("m_addr_hold", bus.m_addr, v.e_addr);
            chk("m_data_hold", bus.m_data, v.e_data);
            last_done = cyc;
        end
        last_srv = v.e_gnt;
        tick();
        chk("gap_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        chk("gap_done", {bus.done1, bus.done0}, 2'b00);
        chk("gap_nack", {bus.nack, bus.timeout}, 2'b00);
        if (v.e_gnt == 0) bus.req0 = 1'b0;
        else              bus.req1 = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   {bus.gnt1, bus.gnt0}, 2'b00);
        chk({tag, "_done"},  {bus.done1, bus.done0}, 2'b00);
        chk({tag, "_flags"}, {bus.nack, bus.timeout, bus.m_start}, 3'b000);
        chk({tag, "_rdata"}, bus.rdata, 8'h00);
        chk({tag, "_maddr"}, bus.m_addr, 8'h00);
        chk({tag, "_mdata"}, bus.m_data, 8'h00);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.m_done = 0; bus.m_nack = 0; bus.m_rdata = 0;

        //          r0 r1 ip  a0     w0     a1     w1     d   mn mr     gnt lat rdata  nk to
        tbl[0]  = mk(1, 1, 0, 8'h10, 8'h11, 8'h20, 8'h21, 2,  0, 8'h00, 0,  3, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 0, 8'h12, 8'h13, 8'h22, 8'h23, 1,  0, 8'h01, 1,  2, 8'h01, 0, 0);
        tbl[2]  = mk(1, 1, 0, 8'h14, 8'h15, 8'h24, 8'h25, 3,  0, 8'h02, 0,  4, 8'h02, 0, 0);
        tbl[3]  = mk(1, 1, 0, 8'h16, 8'h17, 8'h26, 8'h27, 2,  0, 8'h03, 1,  3, 8'h03, 0, 0);
        tbl[4]  = mk(1, 0, 1, 8'h66, 8'hF0, 8'h00, 8'h00, 3,  0, 8'h00, 0,  4, 8'h00, 0, 0);
        tbl[5]  = mk(0, 1, 1, 8'h00, 8'h00, 8'h67, 8'h00, 1,  0, 8'hA5, 1,  2, 8'hA5, 0, 0);
        tbl[6]  = mk(1, 0, 1, 8'h4E, 8'hC3, 8'h00, 8'h00, 2,  1, 8'h3C, 0,  3, 8'h3C, 1, 0);
        tbl[7]  = mk(0, 1, 1, 8'h00, 8'h00, 8'h91, 8'h7E, -1, 0, 8'h00, 1, 16, 8'h00, 1, 1);
        tbl[8]  = mk(1, 0, 1, 8'hA0, 8'h55, 8'h00, 8'h00, 15, 0, 8'h5A, 0, 16, 8'h5A, 0, 0);
        tbl[9]  = mk(1, 0, 1, 8'hA2, 8'h56, 8'h00, 8'h00, 0,  0, 8'hFF, 0, 16, 8'h00, 1, 1);
        tbl[10] = mk(1, 1, 1, 8'hB0, 8'h18, 8'hB2, 8'h19, 4,  0, 8'h77, 1,  5, 8'h77, 0, 0);

        #22;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset in the middle of WAIT: silent abort, then pending REQ1 served.
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.addr0 = 8'hC4; bus.wdata0 = 8'hE7;
        repeat (G + 3) tick();
        chk("pre_rst_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
        bus.req1 = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        bus.req0 = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_no_done", {bus.done1, bus.done0}, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_srv = 1;
        last_done = -1;
        apply(mk(0, 1, 0, 8'h00, 8'h00, 8'h3A, 8'h9B, 2, 0, 8'h42, 1, 3, 8'h42, 0, 0));

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(1, 3);
            rv.r0 = k[0]; rv.r1 = k[1];
            rv.idle_pre = 1'($urandom);
            rv.a0 = 8'($urandom); rv.w0 = 8'($urandom);
            rv.a1 = 8'($urandom); rv.w1 = 8'($urandom);
            rv.d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 2));
            rv.mn = 1'($urandom);
            rv.mr = 8'($urandom);
            apply(model(rv));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master datapath (SDA driver, 8-bit Address/Data in, 8-bit Data_OUT) between two requesters.
- Round-robin arbitration; sequences one complete master transaction per grant, with a timeout watchdog and an enforced bus-free gap.
- Sits between the requester logic and the I2C master core; every signal is registered in the CLK domain.

Parameters:
- TIMEOUT_CYCLES, 4096, max CLK cycles in WAIT before forced abort (≥2)
- GAP_CYCLES, 2, idle cycles enforced after each transaction before next grant (≥1)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ0, REQ1  in  1  requester n wants bus; held high until its DONEn
- ADDR0, ADDR1  in  8  {7-bit slave address, R/W in bit0 (1=read)}
- WDATA0, WDATA1  in  8  write byte
- GNT0, GNT1  out  1  requester n owns the bus (ISSUE through RESP)
- DONE0, DONE1  out  1  one-cycle completion pulse to requester n
- RDATA  out  8  read byte, valid while DONEx=1
- NACK  out  1  slave NACK or timeout, valid while DONEx=1
- TIMEOUT  out  1  watchdog abort, valid while DONEx=1
- M_START  out  1  one-cycle start pulse to master core
- M_ADDR  out  8  latched address to master
- M_DATA  out  8  latched write byte to master
- M_DONE  in  1  master completion pulse
- M_NACK  in  1  master ack-error, valid with M_DONE
- M_RDATA  in  8  master Data_OUT, valid with M_DONE

Behaviour:
- Reset (async, RST_N=0): state=IDLE, all outputs 0, M_ADDR=M_DATA=RDATA=0, last-served pointer=1 (requester 0 wins the first tie), timeout and gap counters cleared. Reset mid-transaction aborts silently; no DONE pulse.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE: at an edge with REQ0|REQ1=1, choose the winner: the sole requester, or on a tie the one not last served. Latch its ADDR/WDATA into M_ADDR/M_DATA, set GNTn, go to ISSUE.
- ISSUE: M_START=1 for exactly this cycle; next state WAIT; clear timeout counter.
- WAIT: counter increments each cycle.
  - M_DONE=1: capture M_RDATA→RDATA and M_NACK→NACK, TIMEOUT=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without M_DONE: NACK=1, TIMEOUT=1, RDATA=0, go to RESP.
  - M_DONE and the timeout in the same cycle: M_DONE wins.
  - M_DONE outside WAIT is ignored.
- RESP: DONEn=1 for one cycle to the granted requester only; RDATA/NACK/TIMEOUT held valid. Update last-served=n. Next state GAP.
- GAP: GNT0=GNT1=0, DONE=0, NACK/TIMEOUT cleared; stay GAP_CYCLES cycles, then IDLE.
- Latency: REQ sampled high in IDLE at edge k → GNT high from cycle k+1, M_START at k+1, earliest DONE at k+3 (M_DONE at k+2).
- Requester drops REQ after grant: transaction still completes and DONE is still pulsed. ADDR/WDATA changes after the latch have no effect.
- GNT is one-hot or zero at all times; M_ADDR/M_DATA stay stable from ISSUE until the next latch.
- Throughput: one transaction per 4+GAP_CYCLES cycles minimum; with both REQs held, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset then REQ0=1, ADDR0=8'h66, WDATA0=8'hF0; M_DONE at 3 cycles after M_START, M_NACK=0 → M_ADDR=8'h66, M_DATA=8'hF0, one M_START pulse, DONE0 pulse, NACK=0, GNT1 never high.
- REQ0=REQ1=1 simultaneously from reset, each held until its DONE, then re-raised → grant order 0,1,0,1; at least GAP_CYCLES=2 idle cycles between DONE and next M_START.
- Read: REQ1=1, ADDR1=8'h67, M_DONE with M_RDATA=8'hA5 → DONE1 with RDATA=8'hA5, NACK=0.
- Slave NACK: M_DONE with M_NACK=1 → DONEx with NACK=1, TIMEOUT=0.
- Watchdog: TIMEOUT_CYCLES=16, M_DONE never asserted → DONE pulse 16 cycles after M_START, NACK=1, TIMEOUT=1, RDATA=0. Repeat with M_DONE on the final count cycle → TIMEOUT=0.
- RST_N pulled low during WAIT → all outputs 0 asynchronously, no DONE. After release, the pending REQ1 is served with requester 0 idle.
